// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder controller: FSM states and counter sizing.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 8;

   // The bit counter only has to reach WIDTH-1, so $clog2(WIDTH) bits suffice.
   function automatic int cnt_w(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

   localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and serial_adder_ctrl.
// Ovf is present only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_ctrl_if #(
   parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic             Ovf;

   modport master (output Start, A, B, Cin, input Busy, Done, Sum, Cout, Ovf);
   modport slave  (input Start, A, B, Cin, output Busy, Done, Sum, Cout, Ovf);
`else
   modport master (output Start, A, B, Cin, input Busy, Done, Sum, Cout);
   modport slave  (input Start, A, B, Cin, output Busy, Done, Sum, Cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl_full_adder.sv
// The shared one-bit full-adder cell driven bit-serially by serial_adder_ctrl.
module Full_Adder (
   input  logic A,
   input  logic B,
   input  logic Cin,
   output logic S,
   output logic Cout
);
   assign S    = A ^ B ^ Cin;
   assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one Full_Adder over WIDTH cycles, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output Ovf.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                CLK,
   input  logic                RST,
   serial_adder_ctrl_if.slave  bus
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic [WIDTH-2:0] psum;
   logic [WIDTH-1:0] psum_next;
   logic [WIDTH-1:0] sum_q;
   logic [CW-1:0]    cnt_q;
   logic             carry_q;
   logic             cout_q;
   logic             fa_s, fa_cout;
   logic             load, step, last;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q;
`endif

   Full_Adder u_fa (
      .A    (a_sh[0]),
      .B    (b_sh[0]),
      .Cin  (carry_q),
      .S    (fa_s),
      .Cout (fa_cout)
   );

   // Result bits arrive LSB first, so each new bit enters at the top and slides down.
   assign psum_next = {fa_s, psum};

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.Start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt_q == LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.Start) begin
               load    = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         a_sh    <= '0;
         b_sh    <= '0;
         psum    <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else if (load) begin
         a_sh    <= bus.A;
         b_sh    <= bus.B;
         carry_q <= bus.Cin;
         psum    <= '0;
         cnt_q   <= '0;
      end else if (step) begin
         a_sh    <= a_sh >> 1;
         b_sh    <= b_sh >> 1;
         carry_q <= fa_cout;
         psum    <= psum_next[WIDTH-1:1];
         // Counter stops at LAST rather than wrapping.
         if (!last) cnt_q <= cnt_q + 1'b1;
         if (last) begin
            sum_q  <= psum_next;
            cout_q <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q is the carry into the MSB during the final bit.
            ovf_q  <= carry_q ^ fa_cout;
`endif
         end
      end
   end

   assign bus.Busy = (state_q == RUN);
   assign bus.Done = (state_q == DONE);
   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.Ovf  = ovf_q;
`endif

endmodule
